// File: rtl/battle_turn_controller.sv
// rtl/battle_turn_controller.sv - turn sequencer upstream of the battle damage engine
//
// Purpose: starts a battle on a map collision, alternates player and enemy
// turns with one-cycle strobes and attack choices, ends the battle from the
// engine's HP read-back and holds the result until the game FSM acks it.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   collision_in                  sprite overlap level from the map logic
//   key_valid, key_choice[1:0]    player attack key strobe and choice
//   battle_ack                    game FSM releases the held result
//   player_HP, enemy_HP [7:0]     engine HP read-back
//   player/enemy_remained_*[1:0]  engine weapon counts
//   collision_detected            engine enable (all states but IDLE/DONE)
//   battle_start                  one-cycle pulse in START
//   player_turn, attacker_turn    one-cycle turn strobes
//   player_choice, enemy_choice   latched attack choices
//   key_reject                    key refused: weapon count is 0
//   battle_over, player_won       result, held in DONE
//   turn_count[7:0]               completed rounds, saturating
module battle_turn_controller #(
  parameter int          ENEMY_DELAY = 16,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       collision_in,
  input  logic       key_valid,
  input  logic [1:0] key_choice,
  input  logic       battle_ack,
  input  logic [7:0] player_HP,
  input  logic [7:0] enemy_HP,
  input  logic [1:0] player_remained_sword,
  input  logic [1:0] player_remained_baseballbat,
  input  logic [1:0] enemy_remained_sword,
  input  logic [1:0] enemy_remained_baseballbat,
  output logic       collision_detected,
  output logic       battle_start,
  output logic       player_turn,
  output logic       attacker_turn,
  output logic [1:0] player_choice,
  output logic [1:0] enemy_choice,
  output logic       key_reject,
  output logic       battle_over,
  output logic       player_won,
  output logic [7:0] turn_count
);

  localparam int CNT_W = (ENEMY_DELAY > 1) ? $clog2(ENEMY_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ENEMY_DELAY - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_P_WAIT, S_P_HIT, S_P_SET,
    S_E_WAIT, S_E_HIT, S_E_SET, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       player_choice_q, player_choice_d;
  logic [1:0]       enemy_choice_q, enemy_choice_d;
  logic             key_reject_q, key_reject_d;
  logic             player_won_q, player_won_d;
  logic [7:0]       turn_count_q, turn_count_d;
  logic [1:0]       enemy_pick;

  // Enemy cannot use a weapon it has run out of; fall back to kick.
  always_comb begin
    enemy_pick = lfsr_q[1:0];
    if ((enemy_pick == 2'b10 && enemy_remained_baseballbat == 2'd0) ||
        (enemy_pick == 2'b11 && enemy_remained_sword == 2'd0)) begin
      enemy_pick = 2'b01;
    end
  end

  always_comb begin
    state_d         = state_q;
    // Galois LFSR x^8+x^6+x^5+x^4+1, right-shifting form.
    lfsr_d          = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    armed_d         = armed_q;
    cnt_d           = cnt_q;
    player_choice_d = player_choice_q;
    enemy_choice_d  = enemy_choice_q;
    key_reject_d    = 1'b0;
    player_won_d    = player_won_q;
    turn_count_d    = turn_count_q;

    // A collision must drop before another battle may start.
    if (!collision_in) begin
      armed_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (collision_in && armed_q) begin
          state_d      = S_START;
          turn_count_d = 8'd0;
          player_won_d = 1'b0;
          armed_d      = 1'b0;
        end
      end
      S_START: state_d = S_P_WAIT;
      S_P_WAIT: begin
        if (key_valid) begin
          if ((key_choice == 2'b10 && player_remained_baseballbat == 2'd0) ||
              (key_choice == 2'b11 && player_remained_sword == 2'd0)) begin
            key_reject_d = 1'b1;
          end else begin
            player_choice_d = key_choice;
            state_d         = S_P_HIT;
          end
        end
      end
      S_P_HIT: state_d = S_P_SET;
      S_P_SET: begin
        if (enemy_HP == 8'd0) begin
          player_won_d = 1'b1;
          state_d      = S_DONE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = S_E_WAIT;
        end
      end
      S_E_WAIT: begin
        if (cnt_q == '0) begin
          enemy_choice_d = enemy_pick;
          state_d        = S_E_HIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_E_HIT: state_d = S_E_SET;
      S_E_SET: begin
        if (player_HP == 8'd0) begin
          player_won_d = 1'b0;
          state_d      = S_DONE;
        end else begin
          turn_count_d = (turn_count_q == 8'hFF) ? 8'hFF : turn_count_q + 8'd1;
          state_d      = S_P_WAIT;
        end
      end
      S_DONE: begin
        if (battle_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      lfsr_q          <= LFSR_SEED;
      armed_q         <= 1'b1;
      cnt_q           <= '0;
      player_choice_q <= 2'b00;
      enemy_choice_q  <= 2'b00;
      key_reject_q    <= 1'b0;
      player_won_q    <= 1'b0;
      turn_count_q    <= 8'd0;
    end else begin
      state_q         <= state_d;
      lfsr_q          <= lfsr_d;
      armed_q         <= armed_d;
      cnt_q           <= cnt_d;
      player_choice_q <= player_choice_d;
      enemy_choice_q  <= enemy_choice_d;
      key_reject_q    <= key_reject_d;
      player_won_q    <= player_won_d;
      turn_count_q    <= turn_count_d;
    end
  end

  assign collision_detected = (state_q != S_IDLE) && (state_q != S_DONE);
  assign battle_start       = (state_q == S_START);
  assign player_turn        = (state_q == S_P_HIT);
  assign attacker_turn      = (state_q == S_E_HIT);
  assign battle_over        = (state_q == S_DONE);
  assign player_choice      = player_choice_q;
  assign enemy_choice       = enemy_choice_q;
  assign key_reject         = key_reject_q;
  assign player_won         = player_won_q;
  assign turn_count         = turn_count_q;

endmodule

// File: tb/tb_battle_turn_controller.sv
// tb/tb_battle_turn_controller.sv - scoreboard bench for battle_turn_controller
module tb_battle_turn_controller;

  localparam int ED = 16;
  localparam int K_START = 0, K_PTURN = 1, K_ETURN = 2, K_REJECT = 3, K_DONE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       collision_in = 1'b0;
  logic       key_valid = 1'b0;
  logic [1:0] key_choice = 2'b00;
  logic       battle_ack = 1'b0;
  logic [7:0] player_HP = 8'd100;
  logic [7:0] enemy_HP = 8'd50;
  logic [1:0] p_sword = 2'd3, p_bat = 2'd3, e_sword = 2'd3, e_bat = 2'd3;

  logic       collision_detected, battle_start, player_turn, attacker_turn;
  logic [1:0] player_choice, enemy_choice;
  logic       key_reject, battle_over, player_won;
  logic [7:0] turn_count;

  battle_turn_controller #(.ENEMY_DELAY(ED), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .collision_in(collision_in),
    .key_valid(key_valid), .key_choice(key_choice), .battle_ack(battle_ack),
    .player_HP(player_HP), .enemy_HP(enemy_HP),
    .player_remained_sword(p_sword), .player_remained_baseballbat(p_bat),
    .enemy_remained_sword(e_sword), .enemy_remained_baseballbat(e_bat),
    .collision_detected(collision_detected), .battle_start(battle_start),
    .player_turn(player_turn), .attacker_turn(attacker_turn),
    .player_choice(player_choice), .enemy_choice(enemy_choice),
    .key_reject(key_reject), .battle_over(battle_over),
    .player_won(player_won), .turn_count(turn_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Engine model: reload on battle_start, apply damage on turn strobes.
  logic [7:0] p_dmg = 8'd10, e_dmg = 8'd5, enemy_load = 8'd50;
  always @(posedge clk) begin
    if (battle_start) begin
      player_HP <= 8'd100;
      enemy_HP  <= enemy_load;
    end else begin
      if (player_turn)   enemy_HP  <= (enemy_HP > p_dmg) ? enemy_HP - p_dmg : 8'd0;
      if (attacker_turn) player_HP <= (player_HP > e_dmg) ? player_HP - e_dmg : 8'd0;
    end
  end

  // Reference LFSR; lfsr_prev is the value the DUT saw at the latching edge.
  function automatic logic [7:0] lstep(input logic [7:0] l);
    return {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
  endfunction
  logic [7:0] lfsr_m = 8'hA5, lfsr_prev = 8'hA5;
  always @(posedge clk) begin
    lfsr_prev <= lfsr_m;
    lfsr_m    <= rst ? 8'hA5 : lstep(lfsr_m);
  end

  function automatic int exp_pick();
    logic [1:0] p;
    p = lfsr_prev[1:0];
    if ((p == 2'b10 && e_bat == 2'd0) || (p == 2'b11 && e_sword == 2'd0)) p = 2'b01;
    return int'(p);
  endfunction

  typedef struct {int kind; int data; int at;} ev_t;
  ev_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic string kname(input int k);
    case (k)
      K_START:  return "battle_start";
      K_PTURN:  return "player_turn";
      K_ETURN:  return "attacker_turn";
      K_REJECT: return "key_reject";
      default:  return "battle_over";
    endcase
  endfunction

  task automatic expect_ev(input int kind, input int data, input int at);
    ev_t e;
    e.kind = kind; e.data = data; e.at = at;
    q.push_back(e);
  endtask

  task automatic observe(input int kind, input int data, input int alt);
    ev_t e;
    int  req;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s got data %0d cycle %0d, required no event", kname(kind), data, cyc);
    end else begin
      e   = q.pop_front();
      req = (e.data < 0) ? alt : e.data;
      if (e.kind != kind || e.at != cyc || req != data) begin
        errors++;
        $display("FAIL event_%s got %s data %0d cycle %0d, required %s data %0d cycle %0d",
                 kname(e.kind), kname(kind), data, cyc, kname(e.kind), req, e.at);
      end
    end
  endtask

  logic over_prev = 1'b0;
  always @(negedge clk) begin
    if (battle_start)  observe(K_START, 0, 0);
    if (player_turn)   observe(K_PTURN, int'(player_choice), 0);
    if (attacker_turn) observe(K_ETURN, int'(enemy_choice), exp_pick());
    if (key_reject)    observe(K_REJECT, 0, 0);
    if (battle_over && !over_prev) observe(K_DONE, int'({player_won, turn_count}), 0);
    over_prev = battle_over;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  logic [18:0] outs;
  assign outs = {collision_detected, battle_start, player_turn, attacker_turn,
                 player_choice, enemy_choice, key_reject, battle_over,
                 player_won, turn_count};

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) sync();
  endtask

  // One full player+enemy round starting in P_WAIT; returns in P_WAIT.
  task automatic round(input logic [1:0] ch);
    key_valid = 1'b1; key_choice = ch;
    expect_ev(K_PTURN, int'(ch), cyc + 1);
    expect_ev(K_ETURN, -1, cyc + 1 + ED + 2);
    sync();
    key_valid = 1'b0;
    tick(20);
  endtask

  // Final round in which the player is hit down to 0 HP.
  task automatic losing_round(input int tc);
    e_dmg = 8'd255;
    key_valid = 1'b1; key_choice = 2'b00;
    expect_ev(K_PTURN, 0, cyc + 1);
    expect_ev(K_ETURN, -1, cyc + 19);
    expect_ev(K_DONE, tc, cyc + 21);
    sync();
    key_valid = 1'b0;
    tick(25);
  endtask

  // Ack the held result, then drop and re-raise the collision to start anew.
  task automatic ack_and_restart();
    battle_ack = 1'b1;
    sync();
    battle_ack = 1'b0;
    @(negedge clk);
    chk("ack_battle_over", int'(battle_over), 0);
    chk("ack_collision_detected", int'(collision_detected), 0);
    sync();
    tick(10);
    collision_in = 1'b0;
    tick(2);
    collision_in = 1'b1;
    expect_ev(K_START, 0, cyc + 1);
    tick(2);
  endtask

  initial begin
    tick(3);
    @(negedge clk);
    chk("reset_outputs", int'(outs), 0);
    sync();
    rst = 1'b0;
    tick(2);

    // Battle A: start, timing of first round, reject, enemy defeated.
    collision_in = 1'b1;
    expect_ev(K_START, 0, cyc + 1);
    sync();
    @(negedge clk);
    chk("start_collision_detected", int'(collision_detected), 1);
    sync();
    round(2'b01);
    p_sword = 2'd0;
    key_valid = 1'b1; key_choice = 2'b11;
    expect_ev(K_REJECT, 0, cyc + 1);
    sync();
    key_valid = 1'b0;
    tick(2);
    round(2'b10);
    @(negedge clk);
    chk("player_choice_held", int'(player_choice), 2);
    sync();
    p_dmg = 8'd200;
    key_valid = 1'b1; key_choice = 2'b00;
    expect_ev(K_PTURN, 0, cyc + 1);
    expect_ev(K_DONE, 256 + 2, cyc + 3);
    sync();
    key_valid = 1'b0;
    tick(5);
    @(negedge clk);
    chk("done_held", int'(battle_over), 1);
    sync();

    // Battle B: enemy out of bat and sword; player defeated.
    p_sword = 2'd3; e_bat = 2'd0; e_sword = 2'd0; p_dmg = 8'd0; e_dmg = 8'd0;
    ack_and_restart();
    repeat (200) round(2'b00);
    losing_round(200);

    // Battle C: reset in E_WAIT, then turn_count saturation.
    e_bat = 2'd3; e_sword = 2'd3; e_dmg = 8'd0;
    ack_and_restart();
    key_valid = 1'b1; key_choice = 2'b01;
    expect_ev(K_PTURN, 1, cyc + 1);
    sync();
    key_valid = 1'b0;
    tick(4);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    expect_ev(K_START, 0, cyc + 1);
    @(negedge clk);
    chk("midbattle_reset_outputs", int'(outs), 0);
    sync();
    tick(1);
    repeat (260) round(2'b00);
    losing_round(255);

    chk("pending_events", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
